// File: rtl/sum_stage.sv
// sum_stage: two-stage registered 4-bit lookahead sum with valid/ready handshake.
// Optional modulo correction enabled by defining SUM_STAGE_MOD_CORRECT_EN.
module sum_stage #(
    parameter int MOD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] H,
    input  logic [3:0] G,
    input  logic [3:0] P,
    input  logic       cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] S,
    output logic       cout
);
    if (MOD < 2 || MOD > 16) begin : g_bad_mod
        $error("sum_stage: MOD must be within 2..16");
    end
    logic       v1, v2, adv2;
    logic [4:0] cy, c1_q;
    logic [3:0] h1_q, s_nx;
    logic       co_nx;
    logic [4:0] x;
    assign adv2      = !v2 || out_ready;
    assign in_ready  = !rst && (!v1 || adv2);
    assign out_valid = v2;
    // lookahead carries c0..c4 from the incoming bundle
    always_comb begin
        cy[0] = cin;
        for (int i = 0; i < 4; i++) cy[i+1] = G[i] | (P[i] & cy[i]);
    end
    // stage-2 result from the stage-1 carries and half-sums
    always_comb begin
        x = {c1_q[4], h1_q ^ c1_q[3:0]};
`ifdef SUM_STAGE_MOD_CORRECT_EN
        s_nx  = x >= 5'(MOD) ? 4'(x - 5'(MOD)) : x[3:0];
        co_nx = 1'b0;
`else
        s_nx  = x[3:0];
        co_nx = x[4];
`endif
    end
    // pipeline registers: stage 1 loads on input transfer, stage 2 advances when free or drained
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            c1_q <= '0;
            h1_q <= '0;
            S    <= '0;
            cout <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                v1   <= 1'b1;
                c1_q <= cy;
                h1_q <= H;
            end else if (adv2) begin
                v1 <= 1'b0;
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    S    <= s_nx;
                    cout <= co_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_sum_stage.sv
// tb_sum_stage: randomized scoreboard bench for sum_stage against an arithmetic a+b+cin model.
module tb_sum_stage;
    localparam int MOD = 15;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] H = '0, G = '0, P = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] S;
    logic       cout;
    int checks = 0;
    int errors = 0;
    logic [4:0] q[$];
    logic [4:0] exp_front;
    logic [3:0] a_cur = '0, b_cur = '0;
    logic       hold_pend = 1'b0;
    logic [4:0] hold_val = '0;
    sum_stage #(.MOD(MOD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .H(H), .G(G), .P(P), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .S(S), .cout(cout)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [4:0] model_sum(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int y;
        logic [4:0] r;
        y = int'(a) + int'(b) + int'(ci);
`ifdef SUM_STAGE_MOD_CORRECT_EN
        if (y >= MOD) y = y - MOD;
        r = 5'(y);
        return {1'b0, r[3:0]};
`else
        r = 5'(y);
        return r;
`endif
    endfunction
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v);
        a_cur = a; b_cur = b;
        H = a ^ b; G = a & b; P = a | b; cin = ci; in_valid = v;
    endtask
    // one cycle: inputs already driven at negedge; sample, score, clock, check stall hold
    task automatic tick();
        logic ir, ov;
        logic [4:0] os;
        #1;
        ir = in_ready; ov = out_valid; os = {cout, S};
        if (rst) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (ov && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 32'(os), 32'h1f_dead);
                else begin
                    exp_front = q.pop_front();
                    chk("out_data", 32'(os), 32'(exp_front));
                end
            end
            if (in_valid && ir) q.push_back(model_sum(a_cur, b_cur, cin));
            hold_pend = ov && !out_ready;
            hold_val = os;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold_pend) begin
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'({cout, S}), 32'(hold_val));
        end
    endtask
    task automatic direct(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci,
                          input logic [4:0] exp);
        out_ready = 1'b1;
        drive(a, b, ci, 1'b1);
        tick();
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        #1 chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        #1 chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk(tag, 32'({cout, S}), 32'(exp));
        tick();
    endtask
    task automatic drain(input string tag);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk(tag, 32'(q.size()), 32'd0);
        tick();
    endtask
    initial begin
        logic [3:0] ra, rb;
        int lim;
        lim = MOD;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        direct("t1_5p3", 4'd5, 4'd3, 1'b0, 5'b01000);
`ifdef SUM_STAGE_MOD_CORRECT_EN
        direct("t3_9p7_mod", 4'd9, 4'd7, 1'b0, 5'b00001);
        direct("t5_ripple_mod", 4'd15, 4'd0, 1'b1, 5'b00001);
`else
        direct("t2_9p7", 4'd9, 4'd7, 1'b0, 5'b10000);
        direct("t5_ripple", 4'd15, 4'd0, 1'b1, 5'b10000);
`endif
        out_ready = 1'b1;
        drive(4'd1, 4'd2, 1'b0, 1'b1);
        tick();
        drive(4'd3, 4'd4, 1'b1, 1'b1);
        tick();
        #1 chk("t4_first_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b1);
            if (i == 0) tick();
            else begin
                #1 chk("t4_in_ready_full", 32'(in_ready), 32'd0);
                tick();
            end
        end
        #1 chk("t4_in_ready_stalled", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        drive(4'd6, 4'd2, 1'b0, 1'b1);
        tick();
        drive(4'd7, 4'd7, 1'b0, 1'b1);
        tick();
        drain("t4_drain");
        out_ready = 1'b0;
        drive(4'd2, 4'd2, 1'b0, 1'b1);
        tick();
        drive(4'd4, 4'd1, 1'b1, 1'b1);
        tick();
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("t6_out_valid_after_rst", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t6_no_stale", 32'(out_valid), 32'd0);
            tick();
        end
        direct("t6_after_rst", 4'd2, 4'd3, 1'b1, 5'b00110);
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(lim - 1));
            rb = 4'($urandom_range(lim - 1));
            drive(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(3) != 0));
            out_ready = 1'($urandom_range(2) != 0);
            tick();
        end
        drain("rand_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sum_stage.md
SUM_STAGE -- requirements
Module: sum_stage

Interface
REQ-001 Parameter: MOD, default 15, modulus for optional correction; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  H/G/P/cin bundle valid this cycle.
REQ-005 in_ready  output  1  stage can accept bundle this cycle.
REQ-006 H  input  4  per-bit half-sum (a^b), bit 3 = MSB.
REQ-007 G  input  4  per-bit generate (a&b).
REQ-008 P  input  4  per-bit propagate (a|b).
REQ-009 cin  input  1  carry into bit 0.
REQ-010 out_valid  output  1  S/cout valid.
REQ-011 out_ready  input  1  consumer accepts S/cout this cycle.
REQ-012 S  output  4  sum result.
REQ-013 cout  output  1  carry out of bit 3.

Function
REQ-014 Transfer occurs only on a cycle with valid and ready both high, on either port.
REQ-015 Stage 1 register, loaded on input transfer: lookahead carries c1..c4 with c0 = cin and c[i+1] = G[i] | (P[i] & c[i]), plus H.
REQ-016 Stage 2 register, loaded from stage 1: S = H ^ {c3,c2,c1,c0}, cout = c4.
REQ-017 Latency: 2 cycles from input transfer to out_valid with out_ready held high; throughput 1 bundle/cycle.
REQ-018 in_ready = !v1 | !v2 | out_ready, where v1/v2 are the stage valid flags; purely combinational, no combinational path from in_valid.
REQ-019 Stall: out_valid && !out_ready holds S, cout and out_valid stable; stage 1 holds when stage 2 cannot advance.
REQ-020 Simultaneous output transfer and stage-1 advance in the same cycle: no bundle lost or duplicated.
REQ-021 Bundles leave in acceptance order; no reordering.
REQ-022 Inputs are sampled only on transfer; H/G/P/cin changes while in_ready is low have no effect.
REQ-023 Inconsistent H/G/P combinations are processed per REQ-015/016 without error indication.

Reset
REQ-024 While rst is high: v1 = v2 = 0, out_valid = 0, S = 0000, cout = 0, in_ready = 0.
REQ-025 First cycle after rst deasserts: in_ready = 1.
REQ-026 rst mid-operation discards all in-flight bundles; none appear at the output afterward.

Configuration
REQ-027 Macro SUM_STAGE_MOD_CORRECT_EN defined: stage 2 forms the 5-bit value X = {c4, H^c}; it outputs X - MOD when X >= MOD, otherwise X.
REQ-028 With the macro defined: S = result[3:0], cout = 0; operands are guaranteed < MOD by the producer.
REQ-029 With the macro defined: latency and handshake are unchanged.
REQ-030 Macro undefined: plain binary sum per REQ-016; parameter MOD is unused.

Verification
REQ-031 Test 1: H=0110, G=0001, P=0111, cin=0 (5+3), out_ready=1 -> after 2 cycles S=1000, cout=0.
REQ-032 Test 2, macro undefined: H=1110, G=0001, P=1111, cin=0 (9+7) -> S=0000, cout=1.
REQ-033 Test 3, macro defined, MOD=15: same input as Test 2 -> S=0001, cout=0. Same test with 5+3 -> S=1000.
REQ-034 Test 4: stream of 4 bundles with out_ready low for 3 cycles after the first result -> out_valid and S held stable; in_ready drops once both stages are full; all 4 results delivered in order.
REQ-035 Test 5: H=1111, G=0000, P=1111, cin=1 (full ripple) -> S=0000, cout=1 (macro undefined).
REQ-036 Test 6: rst asserted for 1 cycle with 2 bundles in flight -> out_valid=0 next cycle; no stale result emitted; next accepted bundle produces correct output 2 cycles later.
